// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, sum} = a + b + cin with one cycle of latency,
// plus a signed-overflow flag and a sticky carry-out exception flag.
module full_adder #(
  parameter int unsigned WIDTH = 1  // legal range 1..32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             exc_clr_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             exc_o
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             exc_q, exc_d;

  // Bit-cell ripple chain, LSB to MSB.
  always_comb begin
    carry    = '0;
    prop     = '0;
    sum_c    = '0;
    carry[0] = cin_i;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      prop[i]    = a_i[i] ^ b_i[i];
      sum_c[i]   = prop[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (prop[i] & carry[i]);
    end
  end

  assign cout_c = carry[WIDTH];
  assign ovf_c  = carry[WIDTH] ^ carry[WIDTH-1];

  // Result registers load only on valid, so unknown operands on idle cycles never land.
  always_comb begin
    valid_d = in_valid_i;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    exc_d   = exc_q;
    if (in_valid_i) begin
      sum_d  = sum_c;
      cout_d = cout_c;
      ovf_d  = ovf_c;
    end
    // A fresh carry-out takes priority over a clear on the same edge.
    if (in_valid_i && cout_c) begin
      exc_d = 1'b1;
    end else if (exc_clr_i) begin
      exc_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      exc_q   <= exc_d;
    end
  end

  assign out_valid_o = valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign exc_o       = exc_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1 and WIDTH=16: directed tables, hand sequences for
// hold/reset/clear corners, and random traffic against an arithmetic reference model.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic rst1, v1, a1, b1, cin1, clr1;
  logic ov1, s1, co1, of1, e1;
  // WIDTH=16 instance
  logic        rst16, v16, cin16, clr16;
  logic [15:0] a16, b16, s16;
  logic        ov16, co16, of16, e16;

  full_adder #(.WIDTH(1)) u_fa1 (
    .clk_i(clk), .rst_i(rst1), .in_valid_i(v1), .a_i(a1), .b_i(b1), .cin_i(cin1),
    .exc_clr_i(clr1), .out_valid_o(ov1), .sum_o(s1), .cout_o(co1), .ovf_o(of1), .exc_o(e1)
  );

  full_adder #(.WIDTH(16)) u_fa16 (
    .clk_i(clk), .rst_i(rst16), .in_valid_i(v16), .a_i(a16), .b_i(b16), .cin_i(cin16),
    .exc_clr_i(clr16), .out_valid_o(ov16), .sum_o(s16), .cout_o(co16), .ovf_o(of16),
    .exc_o(e16)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m1v, m1s, m1c, m1o, m1e;
  logic        m16v, m16c, m16o, m16e;
  logic [15:0] m16s;

  function automatic logic [16:0] add_ref(int w, logic [15:0] a, logic [15:0] b, logic cin);
    longint unsigned r;
    r = longint'(a) + longint'(b) + longint'(cin);
    r = r & ((longint'(1) << (w + 1)) - 1);
    return r[16:0];
  endfunction

  // Overflow: the two's complement sum lies outside the signed range of w bits.
  function automatic logic ovf_ref(int w, logic [15:0] a, logic [15:0] b, logic cin);
    longint sa, sb, r, lim;
    lim = longint'(1) << (w - 1);
    sa  = longint'(a);
    sb  = longint'(b);
    if (sa >= lim) sa = sa - (lim << 1);
    if (sb >= lim) sb = sb - (lim << 1);
    r = sa + sb + longint'(cin);
    return (r > lim - 1) || (r < -lim);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance both models from the inputs seen at the edge, then compare.
  task automatic cyc();
    logic [16:0] r;
    @(posedge clk);
    if (rst1) begin
      m1v = 0; m1s = 0; m1c = 0; m1o = 0; m1e = 0;
    end else begin
      m1v = v1;
      if (v1) begin
        r   = add_ref(1, {15'd0, a1}, {15'd0, b1}, cin1);
        m1s = r[0];
        m1c = r[1];
        m1o = ovf_ref(1, {15'd0, a1}, {15'd0, b1}, cin1);
      end
      if (v1 && m1c) m1e = 1;
      else if (clr1) m1e = 0;
    end
    if (rst16) begin
      m16v = 0; m16s = 0; m16c = 0; m16o = 0; m16e = 0;
    end else begin
      m16v = v16;
      if (v16) begin
        r    = add_ref(16, a16, b16, cin16);
        m16s = r[15:0];
        m16c = r[16];
        m16o = ovf_ref(16, a16, b16, cin16);
      end
      if (v16 && m16c) m16e = 1;
      else if (clr16) m16e = 0;
    end
    #1;
    check("w1_valid", ov1, m1v);
    check("w1_sum", s1, m1s);
    check("w1_cout", co1, m1c);
    check("w1_ovf", of1, m1o);
    check("w1_exc", e1, m1e);
    check("w16_valid", ov16, m16v);
    check("w16_sum", s16, m16s);
    check("w16_cout", co16, m16c);
    check("w16_ovf", of16, m16o);
    check("w16_exc", e16, m16e);
  endtask

  typedef struct {
    logic a, b, cin;
    logic sum, cout;
  } vec1_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, clr;
    logic [15:0] sum;
    logic        cout, ovf, exc;
  } vec16_t;

  vec1_t  t1[8];
  vec16_t t16[6];

  initial begin
    t1[0] = '{0, 0, 0, 0, 0};  t1[1] = '{0, 0, 1, 1, 0};
    t1[2] = '{0, 1, 0, 1, 0};  t1[3] = '{0, 1, 1, 0, 1};
    t1[4] = '{1, 0, 0, 1, 0};  t1[5] = '{1, 0, 1, 0, 1};
    t1[6] = '{1, 1, 0, 0, 1};  t1[7] = '{1, 1, 1, 1, 1};
    // Sequential: exc state carries from row to row.
    t16[0] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1};
    t16[1] = '{16'h0001, 16'h0001, 0, 1, 16'h0002, 0, 0, 0};
    t16[2] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0};
    t16[3] = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 1};
    t16[4] = '{16'hFFFF, 16'h0001, 0, 1, 16'h0000, 1, 0, 1};
    t16[5] = '{16'h1234, 16'h1111, 1, 0, 16'h2346, 0, 0, 1};

    rst1 = 1; v1 = 0; a1 = 0; b1 = 0; cin1 = 0; clr1 = 0;
    rst16 = 1; v16 = 0; a16 = 0; b16 = 0; cin16 = 0; clr16 = 0;
    cyc();
    cyc();
    check("rst_w16_out", {ov16, co16, of16, e16, s16}, 32'd0);
    check("rst_w1_out", {ov1, s1, co1, of1, e1}, 32'd0);
    rst1 = 0; rst16 = 0;

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      v1 = 1; a1 = t1[i].a; b1 = t1[i].b; cin1 = t1[i].cin;
      cyc();
      check("tbl1_valid", ov1, 1'b1);
      check("tbl1_sum", s1, t1[i].sum);
      check("tbl1_cout", co1, t1[i].cout);
    end
    v1 = 0;
    cyc();
    check("w1_valid_drop", ov1, 1'b0);

    // WIDTH=16 directed
    for (int i = 0; i < 6; i++) begin
      v16 = 1; a16 = t16[i].a; b16 = t16[i].b; cin16 = t16[i].cin; clr16 = t16[i].clr;
      cyc();
      check("tbl16_valid", ov16, 1'b1);
      check("tbl16_sum", s16, t16[i].sum);
      check("tbl16_cout", co16, t16[i].cout);
      check("tbl16_ovf", of16, t16[i].ovf);
      check("tbl16_exc", e16, t16[i].exc);
    end
    clr16 = 0;

    // Hold: idle cycles with random and unknown operands
    for (int i = 0; i < 3; i++) begin
      v16 = 0;
      if (i == 2) begin
        a16 = 'x; b16 = 'x; cin16 = 1'bx;
      end else begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      end
      cyc();
      check("hold_valid", ov16, 1'b0);
      check("hold_sum", s16, 16'h2346);
    end
    cin16 = 0;

    // Reset mid-stream with exc set and a valid operand on the reset edge
    v16 = 1; a16 = 16'h0010; b16 = 16'h0020;
    cyc();
    a16 = 16'hFFFF; b16 = 16'h0001;
    cyc();
    check("pre_rst_exc", e16, 1'b1);
    rst16 = 1; a16 = 16'h1111; b16 = 16'h2222;
    cyc();
    check("mid_rst_out", {ov16, co16, of16, e16, s16}, 32'd0);
    rst16 = 0; a16 = 16'h0003; b16 = 16'h0004;
    cyc();
    check("post_rst_valid", ov16, 1'b1);
    check("post_rst_sum", s16, 16'h0007);
    v16 = 0;
    cyc();

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      clr1 = ($urandom_range(0, 3) == 0);
      rst1 = ($urandom_range(0, 31) == 0);
      v16 = ($urandom_range(0, 3) != 0);
      a16 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b16 = 16'($urandom); cin16 = 1'($urandom);
      clr16 = ($urandom_range(0, 3) == 0);
      rst16 = ($urandom_range(0, 31) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered, parameterizable-width binary full adder: computes a + b + cin.
- Outputs one cycle later, with carry-out, signed-overflow and sticky exception flags.
- Default WIDTH=1 gives the leaf bit cell of the ripple-carry chain (4-bit ripple stages, 16-bit adder).
- Wider instances serve as a standalone registered adder.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A (unsigned; two's complement for ovf)
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- exc_clr  input  1  clears sticky exception flag
- out_valid  output  1  registered result valid
- sum  output  WIDTH  registered sum bits
- cout  output  1  registered carry-out of MSB
- ovf  output  1  registered signed overflow
- exc  output  1  sticky flag: carry-out seen since last clear

Behaviour:
- Bit cell for each bit i, carry c0=cin:
  - s_i = a_i XOR b_i
  - sum_i = s_i XOR c_i
  - c_{i+1} = (a_i AND b_i) OR (s_i AND c_i)
- Carry ripples LSB to MSB, entirely combinational before the output register.
- cout = c_WIDTH.
- ovf = c_WIDTH XOR c_{WIDTH-1}. For WIDTH=1, ovf = cout XOR cin.
- {cout, sum} equals a + b + cin exactly, modulo 2^(WIDTH+1); no truncation of the carry.
- Latency is 1 cycle:
  - When in_valid=1 at rising edge N, sum/cout/ovf take that result after edge N and out_valid=1.
  - When in_valid=0 at an edge, out_valid=0; sum/cout/ovf hold their previous values.
- Sticky exception:
  - exc sets on the edge that captures a valid result with cout=1.
  - exc stays set until exc_clr=1 or rst=1.
  - If exc_clr=1 and a new cout=1 result are captured on the same edge, set wins: exc=1.
  - exc_clr has no other effect.
- Reset (rst=1 at a rising edge) forces out_valid=0, sum=0, cout=0, ovf=0, exc=0.
  - Reset overrides in_valid and exc_clr on that edge.
  - rst asserted mid-stream discards the operand presented on that edge.
  - The first valid capture after rst deasserts behaves normally.
- Back-to-back in_valid is accepted every cycle (throughput 1/cycle). No backpressure.
- X/Z on inputs while in_valid=0 must not propagate to registered outputs.

Test Plan:
- WIDTH=1 exhaustive, all 8 (a,b,cin) combos with in_valid=1:
  - (0,0,0)→sum0 cout0
  - (1,0,0)→1,0
  - (1,1,0)→0,1
  - (1,1,1)→1,1
  - out_valid=1 exactly one cycle after each input.
- WIDTH=16:
  - 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0, exc=1 next cycle.
  - Then exc_clr=1 with 0x0001+0x0001 → sum=0x0002, cout=0, exc=0.
- WIDTH=16 signed overflow:
  - 0x7FFF+0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 → sum=0x0000, cout=1, ovf=1.
- Hold and valid behaviour:
  - Load 0x1234+0x1111, cin=1 → sum=0x2346.
  - Drop in_valid for 3 cycles with random a/b → out_valid=0 and sum stays 0x2346.
- Reset mid-stream:
  - Stream valid operands, assert rst for one edge with in_valid=1 and exc set.
  - Next cycle: all outputs 0, out_valid=0.
  - The following valid operand appears normally one cycle later.
- Simultaneous clear/set:
  - exc=1, exc_clr=1 together with 0xFFFF+0x0001 → exc remains 1.
